// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode, width and result types
// for the registered ALU and its multiplier.
package alu_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SHL = 3'b101,
    OP_SHR = 3'b110,
    OP_MUL = 3'b111
  } op_e;

  typedef struct packed {
    logic                 carry;
    logic [WIDTH_DEF-1:0] out;
  } res_t;

endpackage

// File: rtl/alu_if.sv
// alu_if: operand/opcode request bundle and
// registered result/flag/ready response.
interface alu_if #(
  parameter int WIDTH = alu_pkg::WIDTH_DEF
) (
  input logic clk,
  input logic nrst
);

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op_code;
  logic             carry;
  logic             ready;
  logic [WIDTH-1:0] out;

  modport master (
    output a, b, op_code,
    input  carry, ready, out
  );

  modport slave (
    input  a, b, op_code,
    output carry, ready, out
  );

endinterface

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: iterative shift-add unsigned
// multiplier, one partial product per clock.
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] prod
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               last;

  assign last = (cnt_q == CW'(WIDTH - 1));
  assign busy = busy_q;
  assign prod = prod_d;

  // Load on start, else one add/shift step per cycle;
  // done flags the cycle whose product is final.
  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done     = 1'b0;
    if (start) begin
      mcand_d  = {{WIDTH{1'b0}}, a};
      mplier_d = b;
      prod_d   = '0;
      cnt_d    = '0;
      busy_d   = 1'b1;
    end else if (busy_q) begin
      if (mplier_q[0]) begin
        prod_d = prod_q + mcand_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CW'(1);
      if (last) begin
        busy_d = 1'b0;
        done   = 1'b1;
      end
    end
  end

  // Multiplier state; reset aborts any run.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

endmodule

// File: rtl/alu_core.sv
// alu_core: registered ALU, single-cycle ops plus
// a WIDTH-cycle multiply; ready gates acceptance.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input logic  clk,
  input logic  nrst,
  alu_if.slave bus
);

  logic [WIDTH-1:0]   out_q, out_d;
  logic               carry_q, carry_d;
  logic               ready_q, ready_d;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic               mul_start;
  logic               mul_busy;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_prod;
  op_e                op;

  assign op   = op_e'(bus.op_code);
  assign sum  = {1'b0, bus.a} + {1'b0, bus.b};
  assign diff = {1'b0, bus.a} - {1'b0, bus.b};

  alu_mul_seq #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk   (clk),
    .rst   (nrst),
    .start (mul_start),
    .a     (bus.a),
    .b     (bus.b),
    .busy  (mul_busy),
    .done  (mul_done),
    .prod  (mul_prod)
  );

  // Decode accepted op; MUL drops ready until the
  // multiplier reports its final product.
  always_comb begin
    out_d     = out_q;
    carry_d   = carry_q;
    ready_d   = ready_q;
    mul_start = 1'b0;
    if (ready_q) begin
      unique case (op)
        OP_ADD: begin
          out_d   = sum[WIDTH-1:0];
          carry_d = sum[WIDTH];
        end
        OP_SUB: begin
          out_d   = diff[WIDTH-1:0];
          carry_d = diff[WIDTH];
        end
        OP_AND: begin
          out_d   = bus.a & bus.b;
          carry_d = 1'b0;
        end
        OP_OR: begin
          out_d   = bus.a | bus.b;
          carry_d = 1'b0;
        end
        OP_XOR: begin
          out_d   = bus.a ^ bus.b;
          carry_d = 1'b0;
        end
        OP_SHL: begin
          out_d   = bus.a << 1;
          carry_d = bus.a[WIDTH-1];
        end
        OP_SHR: begin
          out_d   = bus.a >> 1;
          carry_d = bus.a[0];
        end
        OP_MUL: begin
          mul_start = 1'b1;
          ready_d   = 1'b0;
        end
      endcase
    end
    if (mul_done) begin
      out_d   = mul_prod[WIDTH-1:0];
      carry_d = |mul_prod[2*WIDTH-1:WIDTH];
      ready_d = 1'b1;
    end
  end

  // Result, flag and ready registers.
  always_ff @(posedge clk) begin
    if (nrst) begin
      out_q   <= '0;
      carry_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      out_q   <= out_d;
      carry_q <= carry_d;
      ready_q <= ready_d;
    end
  end

  assign bus.out   = out_q;
  assign bus.carry = carry_q;
  assign bus.ready = ready_q;

  logic unused_busy;
  assign unused_busy = mul_busy;

endmodule

// File: tb/tb_alu_core.sv
// tb_alu_core: directed and random checks of
// alu_core against an arithmetic reference model.
module tb_alu_core;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic nrst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] exp_out = 8'h00;
  logic       exp_carry = 1'b0;

  always #5 clk = ~clk;

  alu_if #(.WIDTH(8)) bus (.clk(clk), .nrst(nrst));

  alu_core #(.WIDTH(8)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus.slave)
  );

  function automatic res_t model(input int op,
                                 input int unsigned a,
                                 input int unsigned b);
    res_t r;
    int unsigned v;
    r = '0;
    case (op)
      0: begin v = a + b; r.out = 8'(v % 256); r.carry = v > 255; end
      1: begin r.out = 8'((a + 256 - b) % 256); r.carry = a < b; end
      2: r.out = 8'(a) & 8'(b);
      3: r.out = 8'(a) | 8'(b);
      4: r.out = 8'(a) ^ 8'(b);
      5: begin r.out = 8'((a * 2) % 256); r.carry = a >= 128; end
      6: begin r.out = 8'(a / 2); r.carry = (a % 2) == 1; end
      default: begin
        v = a * b;
        r.out = 8'(v % 256);
        r.carry = (v / 256) != 0;
      end
    endcase
    return r;
  endfunction

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_res(input string tag);
    chk({tag, ".out"}, int'(bus.out), int'(exp_out));
    chk({tag, ".carry"}, int'(bus.carry), int'(exp_carry));
    chk({tag, ".ready"}, int'(bus.ready), 1);
  endtask

  task automatic do_op(input int op, input int unsigned a,
                       input int unsigned b, input string tag);
    res_t r;
    bus.op_code = 3'(op);
    bus.a = 8'(a);
    bus.b = 8'(b);
    @(posedge clk); #1;
    r = model(op, a, b);
    exp_out = r.out;
    exp_carry = r.carry;
    chk_res(tag);
  endtask

  task automatic do_mul(input int unsigned a, input int unsigned b,
                        input string tag);
    res_t r;
    int n;
    bus.op_code = 3'b111;
    bus.a = 8'(a);
    bus.b = 8'(b);
    @(posedge clk); #1;
    chk({tag, ".e0_ready"}, int'(bus.ready), 0);
    chk({tag, ".e0_out"}, int'(bus.out), int'(exp_out));
    n = 1;
    while (bus.ready !== 1'b1 && n < 20) begin
      bus.a = 8'($urandom);
      bus.b = 8'($urandom);
      bus.op_code = 3'($urandom);
      @(posedge clk); #1;
      n++;
    end
    chk({tag, ".busy_cycles"}, n - 1, 8);
    r = model(7, a, b);
    exp_out = r.out;
    exp_carry = r.carry;
    chk_res(tag);
  endtask

  initial begin
    int op;
    int unsigned ra, rb;
    bus.a = 8'h00;
    bus.b = 8'h00;
    bus.op_code = 3'b000;
    nrst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    exp_out = 8'h00;
    exp_carry = 1'b0;
    chk_res("reset");
    nrst = 1'b0;

    do_op(0, 8'h03, 8'h04, "add_3_4");
    chk("add_3_4.lit", int'(bus.out), 8'h07);
    do_op(0, 200, 100, "add_wrap");
    chk("add_wrap.lit", int'(bus.out), 8'h2C);
    do_op(0, 8'hFF, 8'h01, "add_ff_1");
    do_op(1, 5, 7, "sub_borrow");
    chk("sub_borrow.lit", int'(bus.out), 8'hFE);
    do_op(1, 9, 9, "sub_eq");
    do_op(2, 8'hF0, 8'h3C, "and");
    do_op(3, 8'hF0, 8'h3C, "or");
    do_op(4, 8'hF0, 8'h3C, "xor");
    chk("xor.lit", int'(bus.out), 8'hCC);
    do_op(5, 8'h81, 8'hAA, "shl");
    chk("shl.lit", int'(bus.out), 8'h02);
    do_op(6, 8'h81, 8'h55, "shr");
    chk("shr.lit", int'(bus.out), 8'h40);

    do_mul(20, 15, "mul_20_15");
    chk("mul_20_15.lit", int'(bus.out), 8'h2C);
    do_mul(12, 10, "mul_12_10");
    do_mul(0, 8'hFF, "mul_zero");

    bus.op_code = 3'b111;
    bus.a = 8'hFF;
    bus.b = 8'hFF;
    @(posedge clk); #1;
    chk("rst_mul.e0_ready", int'(bus.ready), 0);
    bus.op_code = 3'b000;
    repeat (3) @(posedge clk);
    #1;
    nrst = 1'b1;
    @(posedge clk); #1;
    exp_out = 8'h00;
    exp_carry = 1'b0;
    chk_res("rst_mul");
    nrst = 1'b0;
    do_op(0, 1, 1, "after_rst");
    chk("after_rst.lit", int'(bus.out), 8'h02);
    repeat (10) begin
      @(posedge clk); #1;
      chk("after_rst.hold", int'(bus.out), 8'h02);
    end
    exp_out = 8'h02;

    do_op(0, 8'h12, 8'h34, "b2b_add");
    do_op(4, 8'h5A, 8'hFF, "b2b_xor");
    do_op(5, 8'hC3, 8'h00, "b2b_shl");

    for (int i = 0; i < 60; i++) begin
      op = int'($urandom_range(0, 7));
      ra = $urandom_range(0, 255);
      rb = $urandom_range(0, 255);
      if (op == 7) do_mul(ra, rb, "rnd_mul");
      else do_op(op, ra, rb, "rnd_op");
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_core.md
Name: alu_core

Overview:
- Registered 8-bit (parameterisable) ALU; one opcode per accepted operation.
- Single-cycle arithmetic, logic and shift ops; a multi-cycle shift-add multiply.
- `ready` tells the driver when the next operation will be accepted.
- Signals are bundled by interface alu_if; operands come from the testbench/datapath side.

Parameters:
- WIDTH, 8, operand and result width in bits.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- nrst  input  1  reset; synchronous and active-high despite its name (1 = reset).
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- op_code  input  3  operation select (encoding below).
- carry  output  1  carry/borrow/overflow flag of the last completed operation.
- ready  output  1  1 = idle, last result valid, next operation accepted this edge.
- out  output  WIDTH  result of the last completed operation.

Behaviour:
- Reset: nrst=1 at a rising edge gives out=0, carry=0, ready=1, multiplier state cleared.
  - Reset has priority over all other activity, including an in-progress MUL; that MUL is aborted with no result.
- Acceptance: a rising edge with nrst=0 and ready=1 samples a, b and op_code. There is no separate start strobe, so an operation is accepted every cycle ready=1.
- Opcodes:
  - 000 ADD: out = (a+b)[WIDTH-1:0]; carry = bit WIDTH of the sum.
  - 001 SUB: out = (a-b) mod 2^WIDTH; carry = borrow (1 iff a<b unsigned).
  - 010 AND: out = a&b; carry=0.
  - 011 OR: out = a|b; carry=0.
  - 100 XOR: out = a^b; carry=0.
  - 101 SHL: out = a<<1; carry = a[WIDTH-1]; b ignored.
  - 110 SHR: logical right shift, out = a>>1; carry = a[0]; b ignored.
  - 111 MUL: unsigned a*b; out = low WIDTH bits; carry = OR of the high WIDTH bits (overflow).
- Single-cycle ops (000-110): out and carry update on the accepting edge; ready stays 1. Back-to-back ops therefore produce one result per cycle.
- MUL timing:
  - Accepting edge E0: ready goes 0; out and carry keep their previous values.
  - One shift-add iteration per edge, E1..E(WIDTH).
  - At E(WIDTH): out and carry update and ready returns to 1, so ready is 0 for exactly WIDTH cycles.
  - While ready=0, a, b and op_code are ignored.
- Outputs are driven from registers only (no combinational input-to-output path).
- All arithmetic is unsigned; results wrap modulo 2^WIDTH with the flag reporting the overflow.
- Boundaries:
  - ADD 0xFF+0x01 gives out=0x00, carry=1.
  - SUB equal operands gives 0, carry=0.
  - MUL by 0 gives 0, carry=0 and still takes WIDTH cycles.

Decomposition:
- Package alu_pkg:
  - WIDTH default constant.
  - opcode enum typedef: OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR, OP_MUL (3-bit).
  - Result struct {carry, out}.
- Interface alu_if bundles clk, nrst, a, b, op_code, carry, ready, out.
- Sub-module alu_mul_seq:
  - Iterative shift-add multiplier with start/busy/done, 2*WIDTH product register, bit counter.
  - alu_core owns the opcode decode, single-cycle datapath and ready control.

Test Plan:
- Reset: hold nrst=1 for 2 cycles -> out=0x00, carry=0, ready=1; release, ADD 0x03+0x04 -> out=0x07, carry=0 on the next edge.
- ADD/SUB wrap: ADD 200+100 -> out=0x2C, carry=1; SUB 5-7 -> out=0xFE, carry=1; SUB 9-9 -> 0x00, carry=0.
- Logic/shift: AND/OR/XOR 0xF0,0x3C -> 0x30/0xFC/0xCC, carry=0; SHL 0x81 -> 0x02, carry=1; SHR 0x81 -> 0x40, carry=1.
- MUL: 20*15 -> ready low exactly 8 cycles, then out=0x2C, carry=1; 12*10 -> out=0x78, carry=0; operands changed while busy do not affect the result.
- Reset mid-MUL: start MUL 0xFF*0xFF, assert nrst after 3 cycles -> out=0, carry=0, ready=1 next edge; a following ADD 1+1 -> out=0x02.
- Back-to-back: ADD, XOR, SHL on consecutive cycles with ready=1 -> three correct results on three consecutive edges; ready never drops.
